// File: rtl/lock_sequencer.sv
// Keypad door-lock sequencer: digit entry, code compare, failed-attempt lockout and unlock window.
// Optional stored-code programming while unlocked is enabled by defining LOCK_CODE_PROGRAM_EN.
module lock_sequencer #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned UNLOCK_CYCLES  = 8,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               key_valid,
    input  logic [DIGIT_W-1:0]                 key_data,
    output logic                               key_ready,
    input  logic                               enter,
    input  logic                               clear,
`ifdef LOCK_CODE_PROGRAM_EN
    input  logic                               prog_valid,
    input  logic [DIGITS*DIGIT_W-1:0]          prog_code,
`endif
    output logic [2:0]                         state,
    output logic                               unlocked,
    output logic                               error,
    output logic                               lockout,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries
);

    localparam int unsigned CODE_W = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMAX   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W  = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_LOCKED   = 3'b000,
        S_INPUT    = 3'b001,
        S_VERIFY   = 3'b010,
        S_ERROR    = 3'b011,
        S_UNLOCKED = 3'b100,
        S_LOCKOUT  = 3'b101
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CODE_W-1:0]  code;
    logic [CODE_W-1:0]  shifted;
    logic [TRY_W-1:0]   tries_inc;
    logic               accept;
    logic               match;

`ifdef LOCK_CODE_PROGRAM_EN
    logic [CODE_W-1:0] code_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q <= DEFAULT_CODE;
        end else if (state_q == S_UNLOCKED && prog_valid) begin
            code_q <= prog_code;
        end
    end

    assign code = code_q;
`else
    assign code = DEFAULT_CODE;
`endif

    assign key_ready = ((state_q == S_LOCKED) || (state_q == S_INPUT)) &&
                       (cnt_q < CNT_W'(DIGITS)) && !enter && !clear;
    assign accept    = key_valid && key_ready;
    assign shifted   = (buf_q << DIGIT_W) | CODE_W'(key_data);
    assign match     = (cnt_q == CNT_W'(DIGITS)) && (buf_q == code);
    // tries never exceeds MAX_TRIES-1 outside VERIFY, so the increment cannot overflow TRY_W
    assign tries_inc = tries_q + TRY_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOCKED;
            buf_q   <= '0;
            cnt_q   <= '0;
            tries_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        timer_d = timer_q;
        case (state_q)
            S_LOCKED: begin
                if (accept) begin
                    state_d = S_INPUT;
                    buf_d   = shifted;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_INPUT: begin
                if (clear) begin
                    state_d = S_LOCKED;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (enter) begin
                    state_d = S_VERIFY;
                end else if (accept) begin
                    buf_d = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_VERIFY: begin
                buf_d = '0;
                cnt_d = '0;
                if (match) begin
                    state_d = S_UNLOCKED;
                    tries_d = '0;
                    timer_d = TMR_W'(UNLOCK_CYCLES - 1);
                end else begin
                    tries_d = tries_inc;
                    if (tries_inc == TRY_W'(MAX_TRIES)) begin
                        state_d = S_LOCKOUT;
                        timer_d = TMR_W'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_ERROR: begin
                state_d = S_LOCKED;
            end
            S_UNLOCKED: begin
                if (enter || timer_q == '0) begin
                    state_d = S_LOCKED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_LOCKED;
                    tries_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase
    end

    assign state    = state_q;
    assign unlocked = (state_q == S_UNLOCKED);
    assign error    = (state_q == S_ERROR);
    assign lockout  = (state_q == S_LOCKOUT);
    assign tries    = tries_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Randomized and directed bench for lock_sequencer against a digit-queue reference model.
// Define LOCK_CODE_PROGRAM_EN to also exercise code programming.
module tb_lock_sequencer;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_data;
    logic        key_ready;
    logic        enter;
    logic        clear;
    logic [2:0]  state;
    logic        unlocked;
    logic        error;
    logic        lockout;
    logic [1:0]  tries;
`ifdef LOCK_CODE_PROGRAM_EN
    logic        prog_valid;
    logic [15:0] prog_code;
`endif

    int checks = 0;
    int errors = 0;

    lock_sequencer #(
        .DIGITS(4),
        .DIGIT_W(4),
        .MAX_TRIES(3),
        .UNLOCK_CYCLES(8),
        .LOCKOUT_CYCLES(16),
        .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_data(key_data),
        .key_ready(key_ready),
        .enter(enter),
        .clear(clear),
`ifdef LOCK_CODE_PROGRAM_EN
        .prog_valid(prog_valid),
        .prog_code(prog_code),
`endif
        .state(state),
        .unlocked(unlocked),
        .error(error),
        .lockout(lockout),
        .tries(tries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending digits, failure count and remaining window lengths.
    int m_ent[$];
    int m_tries;
    int m_unl;
    int m_lko;
    bit m_verify;
    bit m_err;
    int m_code;

    task automatic m_reset();
        m_ent.delete();
        m_tries  = 0;
        m_unl    = 0;
        m_lko    = 0;
        m_verify = 0;
        m_err    = 0;
        m_code   = 'h1234;
    endtask

    function automatic logic [2:0] m_state();
        if (m_verify)          return 3'b010;
        if (m_err)             return 3'b011;
        if (m_unl > 0)         return 3'b100;
        if (m_lko > 0)         return 3'b101;
        if (m_ent.size() > 0)  return 3'b001;
        return 3'b000;
    endfunction

    function automatic bit m_ready(bit e, bit c);
        logic [2:0] s;
        s = m_state();
        return ((s == 3'b000) || (s == 3'b001)) && (m_ent.size() < 4) && !e && !c;
    endfunction

    task automatic m_step(bit v, int d, bit e, bit c, bit r, bit pv, int pc);
        logic [2:0] s;
        int val;
        s = m_state();
        case (s)
            3'b000: if (v && r) m_ent.push_back(d);
            3'b001: begin
                if (c) m_ent.delete();
                else if (e) m_verify = 1;
                else if (v && r) m_ent.push_back(d);
            end
            3'b010: begin
                m_verify = 0;
                val = 0;
                foreach (m_ent[i]) val = val * 16 + m_ent[i];
                if (m_ent.size() == 4 && val == m_code) begin
                    m_tries = 0;
                    m_unl   = 8;
                end else begin
                    m_tries++;
                    if (m_tries == 3) m_lko = 16;
                    else m_err = 1;
                end
                m_ent.delete();
            end
            3'b011: m_err = 0;
            3'b100: begin
`ifdef LOCK_CODE_PROGRAM_EN
                if (pv) m_code = pc;
`endif
                if (e) m_unl = 0;
                else m_unl--;
            end
            3'b101: begin
                m_lko--;
                if (m_lko == 0) m_tries = 0;
            end
            default: ;
        endcase
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs();
        logic [2:0] s;
        s = m_state();
        chk("state",    {29'b0, state},    {29'b0, s});
        chk("unlocked", {31'b0, unlocked}, {31'b0, (s == 3'b100)});
        chk("error",    {31'b0, error},    {31'b0, (s == 3'b011)});
        chk("lockout",  {31'b0, lockout},  {31'b0, (s == 3'b101)});
        chk("tries",    {30'b0, tries},    m_tries);
    endtask

    task automatic cycle(bit v, int d, bit e, bit c, bit pv, int pc);
        bit r;
        @(negedge clk);
        key_valid = v;
        key_data  = 4'(d);
        enter     = e;
        clear     = c;
`ifdef LOCK_CODE_PROGRAM_EN
        prog_valid = pv;
        prog_code  = 16'(pc);
`endif
        #1;
        r = m_ready(e, c);
        chk("key_ready", {31'b0, key_ready}, {31'b0, r});
        @(posedge clk);
        m_step(v, d, e, c, r, pv, pc);
        #1;
        chk_outputs();
    endtask

    task automatic key(int d);
        cycle(1, d, 0, 0, 0, 0);
    endtask

    task automatic press_enter();
        cycle(0, 0, 1, 0, 0, 0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic attempt(int code, int n);
        for (int i = 0; i < n; i++) key((code >> (4 * (n - 1 - i))) & 15);
        press_enter();
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        key_valid = 0;
        enter     = 0;
        clear     = 0;
`ifdef LOCK_CODE_PROGRAM_EN
        prog_valid = 0;
`endif
        #2;
        reset = 0;
        #1;
        m_reset();
        chk({tag, "_state"},     {29'b0, state},     32'd0);
        chk({tag, "_tries"},     {30'b0, tries},     32'd0);
        chk({tag, "_unlocked"},  {31'b0, unlocked},  32'd0);
        chk({tag, "_lockout"},   {31'b0, lockout},   32'd0);
        chk({tag, "_key_ready"}, {31'b0, key_ready}, 32'd1);
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        reset     = 0;
        key_valid = 0;
        key_data  = 0;
        enter     = 0;
        clear     = 0;
`ifdef LOCK_CODE_PROGRAM_EN
        prog_valid = 0;
        prog_code  = 0;
`endif
        m_reset();
        repeat (2) @(posedge clk);
        do_reset("por");

        // Correct entry, then let the unlock window expire
        attempt('h1234, 4);
        chk("t1_verify", {29'b0, state}, 32'd2);
        idle(1);
        chk("t1_unlocked", {31'b0, unlocked}, 32'd1);
        idle(9);
        chk("t1_relocked", {29'b0, state}, 32'd0);

        // Three wrong entries reach lockout; digits are refused during it
        attempt('h1235, 4); idle(2);
        chk("t2_tries1", {30'b0, tries}, 32'd1);
        attempt('h1235, 4); idle(2);
        chk("t2_tries2", {30'b0, tries}, 32'd2);
        attempt('h1235, 4); idle(1);
        chk("t2_lockout", {31'b0, lockout}, 32'd1);
        for (int i = 0; i < 15; i++) cycle(1, 1, i % 3 == 0, i % 5 == 0, 0, 0);
        idle(1);
        chk("t2_tries0", {30'b0, tries}, 32'd0);

        // Short entry errors; overflow digit is refused
        attempt('h123, 3); idle(2);
        do_reset("t3");
        key(1); key(2); key(3); key(4); key(9);
        press_enter(); idle(1);
        chk("t3_overflow_unlock", {31'b0, unlocked}, 32'd1);
        idle(9);

        // clear+enter together, then key_valid+enter together
        key(1); key(2);
        cycle(0, 0, 1, 1, 0, 0);
        chk("t4_clear_wins", {29'b0, state}, 32'd0);
        key(1); key(2); key(3);
        cycle(1, 4, 1, 0, 0, 0);
        idle(2);
        chk("t4_dropped_digit", {30'b0, tries}, 32'd1);

        // Async reset mid-INPUT and mid-LOCKOUT, relock by enter
        key(5); key(6);
        do_reset("t5_input");
        attempt('h1111, 4); idle(2);
        attempt('h1111, 4); idle(2);
        attempt('h1111, 4); idle(4);
        do_reset("t5_lockout");
        attempt('h1234, 4); idle(3);
        press_enter();
        chk("t5_relock", {29'b0, state}, 32'd0);

`ifdef LOCK_CODE_PROGRAM_EN
        // Program a new code while unlocked; programming while locked is ignored
        attempt('h1234, 4); idle(2);
        cycle(0, 0, 0, 0, 1, 'h9876);
        idle(8);
        cycle(0, 0, 0, 0, 1, 'h5555);
        attempt('h9876, 4); idle(1);
        chk("t6_new_code", {31'b0, unlocked}, 32'd1);
        idle(9);
        attempt('h1234, 4); idle(1);
        chk("t6_old_code", {31'b0, error}, 32'd1);
        do_reset("t6");
`endif

        // Randomized attempts biased toward the stored code
        for (int a = 0; a < 40; a++) begin
            int n;
            bit good;
            n    = $urandom_range(2, 5);
            good = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < n; i++) begin
                int d;
                d = (good && i < 4) ? ((m_code >> (4 * (3 - i))) & 15) : int'($urandom_range(0, 15));
                cycle(1, d, 0, ($urandom_range(0, 19) == 0), 0, 0);
            end
            press_enter();
            idle($urandom_range(1, 12));
        end

        // Fully random input traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 15),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 31) == 0), $urandom_range(0, 65535));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Controller that sequences the door-lock state register from keypad events.
- Accepts digits over a valid/ready handshake into a code buffer and compares the entry against the stored code on `enter`.
- Counts failed attempts, enforces a timed lockout and times the unlock window.
- Exposes its 3-bit state for waveform inspection and drives the unlock/error/lockout indicators.

Parameters:
- DIGITS, 4, number of digits in a code.
- DIGIT_W, 4, bits per digit.
- MAX_TRIES, 3, consecutive failures that trigger LOCKOUT (must be ≥1).
- UNLOCK_CYCLES, 8, clock cycles the lock stays UNLOCKED.
- LOCKOUT_CYCLES, 16, clock cycles spent in LOCKOUT.
- DEFAULT_CODE, 16'h1234, stored code after reset (width DIGITS*DIGIT_W).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset values immediately.
- key_valid  in  1  a digit is presented.
- key_data  in  DIGIT_W  digit value.
- key_ready  out  1  the sequencer accepts a digit this cycle.
- enter  in  1  submit the entry (or relock while UNLOCKED).
- clear  in  1  discard the entry and return to LOCKED.
- state  out  3  current state encoding.
- unlocked  out  1  high while in UNLOCKED.
- error  out  1  one-cycle pulse while in ERROR.
- lockout  out  1  high while in LOCKOUT.
- tries  out  $clog2(MAX_TRIES+1)  consecutive failures so far.

Behaviour:
- State encoding: LOCKED=000, INPUT=001, VERIFY=010, ERROR=011, UNLOCKED=100, LOCKOUT=101; 110/111 go to LOCKED next cycle.
- Reset values:
  - state=LOCKED; buffer=0; digit count=0; tries=0; timers=0.
  - key_ready=1; unlocked=error=lockout=0.
  - stored code=DEFAULT_CODE.
- Digit acceptance:
  - A digit is accepted when key_valid & key_ready are both high on a rising edge.
  - key_ready = (state is LOCKED or INPUT) & count<DIGITS & !enter & !clear.
- Buffer:
  - An accepted digit shifts into the low DIGIT_W bits; existing contents shift up.
  - The first digit of a full entry ends in the MSBs.
  - count saturates at DIGITS; no wrap.
- LOCKED:
  - Accepted digit → INPUT with count=1.
  - enter/clear are ignored.
- INPUT:
  - Accepts digits until count==DIGITS; key_ready is low when full.
  - clear → LOCKED; buffer and count cleared.
  - enter → VERIFY.
  - clear and enter together: clear wins.
  - enter and key_valid together: enter wins; the digit is not accepted.
- VERIFY (exactly 1 cycle):
  - Match = (count==DIGITS) & (buffer==code).
  - Match → UNLOCKED; tries=0; timer loaded with UNLOCK_CYCLES-1.
  - Mismatch → tries+1.
    - If tries+1==MAX_TRIES → LOCKOUT; timer loaded with LOCKOUT_CYCLES-1.
    - Otherwise → ERROR.
  - Buffer and count are cleared on leaving VERIFY.
- ERROR: error=1 for exactly one cycle, then LOCKED; tries is retained.
- UNLOCKED:
  - unlocked=1.
  - Timer decrements each cycle; at 0 → LOCKED.
  - enter → LOCKED on the next cycle, regardless of the timer.
  - Digits are refused.
- LOCKOUT:
  - lockout=1; key_ready=0; enter and clear are ignored.
  - At timer 0 → LOCKED with tries=0.
- Latency:
  - enter at edge N: VERIFY visible after edge N; result state visible after edge N+1.
  - unlocked stays high for exactly UNLOCK_CYCLES cycles.
- Reset mid-operation: any state returns to the reset values immediately; a partial entry is lost; tries is cleared.
- Outputs are registered or decoded purely from the registered state; no combinational path from inputs to unlocked/error/lockout.

Optional Feature:
- Macro: LOCK_CODE_PROGRAM_EN.
- Defined:
  - Adds inputs prog_valid (1) and prog_code (DIGITS*DIGIT_W).
  - While state==UNLOCKED and prog_valid=1, the stored code loads prog_code on that edge.
  - prog_valid is ignored in all other states.
  - Reset restores DEFAULT_CODE.
- Undefined: the ports do not exist and the stored code is the constant DEFAULT_CODE.

Test Plan:
1. Correct entry:
   - Stimulus: reset, enter digits 1,2,3,4, then enter.
   - Response: VERIFY for 1 cycle, then unlocked=1 for 8 cycles, then LOCKED; tries=0.
2. Wrong then lockout:
   - Stimulus: enter 1,2,3,5+enter three times.
   - Response: error pulses after attempts 1 and 2; tries goes 1 then 2.
   - Response after attempt 3: LOCKOUT, lockout=1 for 16 cycles, key_ready=0; tries then 0 in LOCKED.
3. Short entry and overflow:
   - Stimulus A: 1,2,3+enter. Response: mismatch, ERROR.
   - Stimulus B: 1,2,3,4,9+enter. Response: 9 is refused (key_ready=0), entry matches, UNLOCKED.
4. Simultaneous events:
   - Stimulus A: clear and enter in the same cycle during INPUT. Response: LOCKED, count=0.
   - Stimulus B: key_valid and enter in the same cycle. Response: the digit is dropped.
5. Reset and relock:
   - Stimulus A: assert reset asynchronously mid-INPUT and mid-LOCKOUT. Response: immediately state=000, tries=0.
   - Stimulus B: enter during UNLOCKED. Response: LOCKED next cycle.
6. With LOCK_CODE_PROGRAM_EN:
   - Stimulus: unlock, apply prog_valid with 16'h9876, let the window expire, then enter 9,8,7,6.
   - Response: unlocks; the old code 1,2,3,4 now errors.
   - Stimulus: prog_valid while LOCKED. Response: ignored.
